// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling mid-bit off a 16-bit bit-time counter; define
// UART_RX_PARITY_EN to add an even-parity bit between data bit 7 and stop.
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       parity_err
);

   // state  | meaning
   // IDLE   | line idle, waiting for a low level
   // START  | wait to mid start bit, reject glitches
   // DATA   | sample 8 data bits LSB first
   // PARITY | sample even-parity bit (UART_RX_PARITY_EN only)
   // STOP   | sample stop bit, publish result
   localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        rx_s;

   assign rx_s = sync2_q;

`ifdef UART_RX_PARITY_EN
   logic perr_q, perr_d;
   logic par_bad_q, par_bad_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 16'd1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d    = 1'b0;
      par_bad_d = par_bad_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d     = 16'd0;
            bit_idx_d = 3'd0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = 16'd0;
               bit_idx_d = 3'd0;
               state_d   = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d              = 16'd0;
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = 16'd0;
               par_bad_d = (^shift_q) ^ rx_s;
               state_d   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               // Leave at mid-stop so a back-to-back start edge is not missed.
               cnt_d   = 16'd0;
               state_d = ST_IDLE;
               if (!rx_s) begin
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad_q) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         cnt_q     <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= rx;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
      end else begin
         perr_q    <= perr_d;
         par_bad_q <= par_bad_d;
      end
   end
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level reference model queues expected
// events, a negedge monitor pops and compares every output pulse.
module tb_uart_rx;
   localparam int CLK_FREQ  = 1_750_000;
   localparam int BAUD_RATE = 100_000;
   localparam int CPB       = CLK_FREQ / BAUD_RATE;   // 17 clocks per bit

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_busy, frame_err, parity_err;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_busy(rx_busy), .frame_err(frame_err), .parity_err(parity_err));

   always #5 clk = ~clk;

   typedef struct { int kind; logic [7:0] data; } ev_t;   // kind 0 valid, 1 frame, 2 parity
   ev_t        exp_q[$];
   int         total = 0;
   int         bad = 0;
   logic [7:0] last_good = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int n;
      n = int'(rx_valid) + int'(frame_err) + int'(parity_err);
      if (n > 1) chk("pulse_exclusive", 32'(n), 32'd1);
      else if (n == 1) begin
         if (exp_q.size() == 0) chk("unexpected_pulse", {rx_valid, frame_err, parity_err}, 3'b000);
         else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("event_kind", rx_valid ? 32'd0 : (frame_err ? 32'd1 : 32'd2), 32'(e.kind));
            chk("event_data", {24'd0, rx_data}, {24'd0, e.data});
         end
      end
   end

   task automatic hold(input logic b, input int n);
      @(negedge clk) rx = b;
      repeat (n - 1) @(negedge clk);
   endtask

   // Reference model: the outcome of a frame follows directly from its stop and parity bits.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int gap);
      ev_t e;
`ifndef UART_RX_PARITY_EN
      par_ok = 1'b1;
`endif
      if (!stop_ok)     begin e.kind = 1; e.data = last_good; end
      else if (!par_ok) begin e.kind = 2; e.data = last_good; end
      else              begin e.kind = 0; e.data = d; last_good = d; end
      exp_q.push_back(e);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      hold((^d) ^ !par_ok, CPB);
`endif
      if (stop_ok) hold(1'b1, CPB);
      else begin
         hold(1'b0, CPB / 2 + 4);
         hold(1'b1, CPB - (CPB / 2 + 4));
         gap = (gap < 2 * CPB) ? 2 * CPB : gap;
      end
      if (gap > 0) hold(1'b1, gap);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 * CPB && exp_q.size() > 0; i++) @(negedge clk);
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("rst_data",  {24'd0, rx_data}, 32'h00);
      chk("rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_busy",  {31'd0, rx_busy}, 32'd0);
      chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
      chk("rst_perr",  {31'd0, parity_err}, 32'd0);
      @(negedge clk) rst = 1'b1;
      hold(1'b1, 2 * CPB);

      send_frame(8'h55, 1'b1, 1'b1, CPB);
      chk("busy_after_55", {31'd0, rx_busy}, 32'd0);
      drain("drain_55");

      hold(1'b0, CPB / 2 - 3);
      chk("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
      rx = 1'b1;
      k = 0;
      while (rx_busy && k < CPB) begin @(negedge clk); k++; end
      chk("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
      hold(1'b1, 2 * CPB);

      send_frame(8'h3C, 1'b1, 1'b1, CPB);
      send_frame(8'hA3, 1'b0, 1'b1, 2 * CPB);
      drain("drain_ferr");
      chk("data_kept_3c", {24'd0, rx_data}, 32'h3C);

      send_frame(8'h00, 1'b1, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 1'b1, CPB);
      drain("drain_b2b");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, CPB);
      send_frame(8'h07, 1'b1, 1'b1, CPB);
      drain("drain_parity");
`endif

      // Abandon a frame in data bit 4 with reset; no event is expected from it.
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(i[0], CPB);
      hold(1'b0, CPB / 2);
      @(negedge clk);
      rst = 1'b0;
      rx  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_data",  {24'd0, rx_data}, 32'h00);
         chk("midrst_busy",  {31'd0, rx_busy}, 32'd0);
         chk("midrst_pulse", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
      end
      last_good = 8'h00;
      @(negedge clk) rst = 1'b1;
      hold(1'b1, 2 * CPB);
      send_frame(8'h81, 1'b1, 1'b1, CPB);
      drain("drain_81");

      for (int i = 0; i < 30; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         send_frame(d, ($urandom % 5) != 0, ($urandom % 5) != 0, int'($urandom_range(0, 2 * CPB)));
      end
      drain("drain_random");
      hold(1'b1, CPB);
      chk("final_busy", {31'd0, rx_busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning the line bit rate in bits/s.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data, output, 8 bits: last correctly received byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port rx_busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.

Function
REQ-011 SHALL define CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide), with 2 <= CLKS_PER_BIT <= 65535, and use a 16-bit bit-time counter.
REQ-012 SHALL pass rx through a two-flop synchronizer preset to 1; all decisions use the synchronized value rx_s.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-014 In IDLE, rx_s==0 SHALL move the block to START with counter=0.
REQ-015 In START, at counter==CLKS_PER_BIT/2-1, rx_s==0 SHALL move to DATA with counter=0 and bit_index=0; rx_s==1 SHALL return to IDLE as a glitch, with no output pulse.
REQ-016 In DATA, at each counter==CLKS_PER_BIT-1, the block SHALL sample rx_s into shift bit bit_index (LSB first), reset counter and increment bit_index; after bit 7 it SHALL go to PARITY if enabled, else STOP.
REQ-017 In STOP, at counter==CLKS_PER_BIT-1 (mid stop bit), rx_s==1 with no parity error SHALL load rx_data, pulse rx_valid for exactly one cycle and go to IDLE.
REQ-018 A sampled stop bit of 0 SHALL pulse frame_err for one cycle, leave rx_data unchanged, suppress rx_valid and go to IDLE.
REQ-019 Returning to IDLE at mid-stop SHALL allow a start edge in the very next cycle, so back-to-back frames are received with no idle gap.
REQ-020 The block SHALL have no buffering: a new valid frame overwrites rx_data regardless of consumer state.
REQ-021 rx_valid, frame_err and parity_err SHALL be registered and mutually exclusive in any cycle.

Reset
REQ-022 With rst==0 at a clk edge, the block SHALL set state=IDLE, counter=0, bit_index=0, rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0 and synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no error pulse; the first start edge after release SHALL be received normally.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state SHALL sample one even-parity bit at counter==CLKS_PER_BIT-1 between data bit 7 and stop.
REQ-025 On a parity mismatch the block SHALL still check the stop bit; it SHALL pulse parity_err (not rx_valid) at the stop sample, leave rx_data unchanged, and let frame_err take priority if the stop bit is also 0.
REQ-026 Macro UART_RX_PARITY_EN undefined: PARITY state and checker SHALL be absent and parity_err SHALL be tied to 0.

Verification (CLK_FREQ=50_000_000, BAUD_RATE=9600, CLKS_PER_BIT=5208)
REQ-027 Send 0x55 with 5208-clock bits -> single rx_valid pulse, rx_data=8'h55, frame_err=0, rx_busy low afterwards.
REQ-028 Drive rx low for 1000 clocks, then high -> no rx_valid or frame_err pulse, rx_busy returns to 0 within 2610 clocks of the falling edge.
REQ-029 Send 0x3C correctly, then 0xA3 with stop bit=0 -> frame_err pulses once, rx_valid=0, rx_data stays 8'h3C.
REQ-030 Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses, with rx_data=8'h00 then 8'hFF.
REQ-031 Pull rst low during data bit 4 of a frame, release it, then send 0x81 -> outputs hold reset values during reset, then one rx_valid with rx_data=8'h81.
REQ-032 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; resend 0x07 with parity bit 1 -> rx_valid with rx_data=8'h07.
